// File: rtl/ex_mem_if.sv
// EX/MEM pipeline bundle: control, data and status signals between the execute-side
// driver and the EX/MEM register. bubble_cnt exists only with EXMEM_BUBBLE_CNT_EN.
interface ex_mem_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              stall;
  logic              flush;
  logic              valid_in;
  logic              RegWrite_in;
  logic              MemtoReg_in;
  logic              MemRead_in;
  logic              MemWrite_in;
  logic              Branch_in;
  logic              Zero_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [DATA_W-1:0] write_data_in;
  logic [REG_W-1:0]  write_reg_in;

  logic              valid_out;
  logic              RegWrite_out;
  logic              MemtoReg_out;
  logic              MemRead_out;
  logic              MemWrite_out;
  logic              Branch_out;
  logic              Zero_out;
  logic [DATA_W-1:0] alu_result_out;
  logic [DATA_W-1:0] write_data_out;
  logic [REG_W-1:0]  write_reg_out;
  logic              pcsrc_out;
`ifdef EXMEM_BUBBLE_CNT_EN
  logic [15:0]       bubble_cnt;

  modport master (
    output stall, flush, valid_in, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
           Branch_in, Zero_in, alu_result_in, write_data_in, write_reg_in,
    input  valid_out, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Branch_out,
           Zero_out, alu_result_out, write_data_out, write_reg_out, pcsrc_out, bubble_cnt
  );
  modport slave (
    input  stall, flush, valid_in, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
           Branch_in, Zero_in, alu_result_in, write_data_in, write_reg_in,
    output valid_out, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Branch_out,
           Zero_out, alu_result_out, write_data_out, write_reg_out, pcsrc_out, bubble_cnt
  );
`else
  modport master (
    output stall, flush, valid_in, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
           Branch_in, Zero_in, alu_result_in, write_data_in, write_reg_in,
    input  valid_out, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Branch_out,
           Zero_out, alu_result_out, write_data_out, write_reg_out, pcsrc_out
  );
  modport slave (
    input  stall, flush, valid_in, RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in,
           Branch_in, Zero_in, alu_result_in, write_data_in, write_reg_in,
    output valid_out, RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out, Branch_out,
           Zero_out, alu_result_out, write_data_out, write_reg_out, pcsrc_out
  );
`endif
endinterface

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register, STAGES (1..4) deep, with stall/flush/reset control.
// Optional feature: define EXMEM_BUBBLE_CNT_EN to add the saturating bubble_cnt output.
module ex_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int STAGES = 1
) (
  input  logic     clk,
  input  logic     reset,
  ex_mem_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              zero;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [REG_W-1:0]  write_reg;
  } stage_t;

  stage_t w_in;
  stage_t w_last;
  stage_t r_stage [STAGES];

  // Bubbles keep their data and Zero but never carry a live control bit.
  always_comb begin
    w_in            = '0;
    w_in.valid      = bus.valid_in;
    w_in.reg_write  = bus.valid_in & bus.RegWrite_in;
    w_in.mem_to_reg = bus.valid_in & bus.MemtoReg_in;
    w_in.mem_read   = bus.valid_in & bus.MemRead_in;
    w_in.mem_write  = bus.valid_in & bus.MemWrite_in;
    w_in.branch     = bus.valid_in & bus.Branch_in;
    w_in.zero       = bus.Zero_in;
    w_in.alu_result = bus.alu_result_in;
    w_in.write_data = bus.write_data_in;
    w_in.write_reg  = bus.write_reg_in;
  end

  // NOTE: pipeline state uses non-blocking assignments so every stage samples the
  // pre-edge value of its predecessor; these are flops, not a memory, so all are reset.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      for (int k = 0; k < STAGES; k++) r_stage[k] <= '0;
    end else if (!bus.stall) begin
      r_stage[0] <= w_in;
      for (int k = 1; k < STAGES; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  assign w_last = r_stage[STAGES-1];

  assign bus.valid_out      = w_last.valid;
  assign bus.RegWrite_out   = w_last.reg_write;
  assign bus.MemtoReg_out   = w_last.mem_to_reg;
  assign bus.MemRead_out    = w_last.mem_read;
  assign bus.MemWrite_out   = w_last.mem_write;
  assign bus.Branch_out     = w_last.branch;
  assign bus.Zero_out       = w_last.zero;
  assign bus.alu_result_out = w_last.alu_result;
  assign bus.write_data_out = w_last.write_data;
  assign bus.write_reg_out  = w_last.write_reg;
  assign bus.pcsrc_out      = w_last.valid & w_last.branch & w_last.zero;

`ifdef EXMEM_BUBBLE_CNT_EN
  logic [15:0] r_bubble_cnt;

  // Counts edges with an empty output slot; flush does not clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (!w_last.valid && r_bubble_cnt != 16'hFFFF) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bus.bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed bench for ex_mem_pipe: three instances (STAGES 1, 2, 3) share one stimulus
// stream; each check targets the instance whose depth the scenario exercises.
module tb_ex_mem_pipe;

  logic clk;
  logic reset;

  logic        s_stall, s_flush, s_valid, s_rw, s_mtr, s_mr, s_mw, s_br, s_zr;
  logic [31:0] s_alu, s_wd;
  logic [4:0]  s_wreg;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_if #(.DATA_W(32), .REG_W(5)) if1 ();
  ex_mem_if #(.DATA_W(32), .REG_W(5)) if2 ();
  ex_mem_if #(.DATA_W(32), .REG_W(5)) if3 ();

  `define TB_DRIVE(IFN) \
    assign IFN.stall = s_stall;  assign IFN.flush = s_flush;  assign IFN.valid_in = s_valid; \
    assign IFN.RegWrite_in = s_rw; assign IFN.MemtoReg_in = s_mtr; assign IFN.MemRead_in = s_mr; \
    assign IFN.MemWrite_in = s_mw; assign IFN.Branch_in = s_br; assign IFN.Zero_in = s_zr; \
    assign IFN.alu_result_in = s_alu; assign IFN.write_data_in = s_wd; assign IFN.write_reg_in = s_wreg;
  `TB_DRIVE(if1)
  `TB_DRIVE(if2)
  `TB_DRIVE(if3)
  `undef TB_DRIVE

  ex_mem_pipe #(.DATA_W(32), .REG_W(5), .STAGES(1)) u_d1 (.clk(clk), .reset(reset), .bus(if1));
  ex_mem_pipe #(.DATA_W(32), .REG_W(5), .STAGES(2)) u_d2 (.clk(clk), .reset(reset), .bus(if2));
  ex_mem_pipe #(.DATA_W(32), .REG_W(5), .STAGES(3)) u_d3 (.clk(clk), .reset(reset), .bus(if3));

  // {valid, RegWrite, MemtoReg, MemRead, MemWrite, Branch, Zero, pcsrc, write_reg, write_data, alu}
  logic [76:0] o1, o2, o3;
  assign o1 = {if1.valid_out, if1.RegWrite_out, if1.MemtoReg_out, if1.MemRead_out, if1.MemWrite_out,
               if1.Branch_out, if1.Zero_out, if1.pcsrc_out, if1.write_reg_out, if1.write_data_out,
               if1.alu_result_out};
  assign o2 = {if2.valid_out, if2.RegWrite_out, if2.MemtoReg_out, if2.MemRead_out, if2.MemWrite_out,
               if2.Branch_out, if2.Zero_out, if2.pcsrc_out, if2.write_reg_out, if2.write_data_out,
               if2.alu_result_out};
  assign o3 = {if3.valid_out, if3.RegWrite_out, if3.MemtoReg_out, if3.MemRead_out, if3.MemWrite_out,
               if3.Branch_out, if3.Zero_out, if3.pcsrc_out, if3.write_reg_out, if3.write_data_out,
               if3.alu_result_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic br, input logic z,
                       input logic [31:0] alu, input logic [4:0] wreg);
    s_valid = v;   s_rw = rw;  s_mtr = 1'b0; s_mr = 1'b0; s_mw = 1'b0;
    s_br    = br;  s_zr = z;   s_alu = alu;  s_wd = 32'h0; s_wreg = wreg;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; s_stall = 1'b0; s_flush = 1'b0;
    bubble();

    // Reset state, with stall and flush also high to show reset dominates.
    s_stall = 1'b1; s_flush = 1'b1;
    step(); step();
    check("reset_d1_all", o1, '0);
    check("reset_d2_all", o2, '0);
    check("reset_d3_all", o3, '0);
    reset = 1'b0; s_stall = 1'b0; s_flush = 1'b0;

    // Single-stage capture.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_00A5, 5'd9);
    step();
    check("s1_valid", if1.valid_out, 1);
    check("s1_regwrite", if1.RegWrite_out, 1);
    check("s1_alu", if1.alu_result_out, 32'hA5);
    check("s1_wreg", if1.write_reg_out, 9);
    check("s1_d2_not_yet", if2.valid_out, 0);

    // Three-stage latency: 1,2,3 enter on edges 1..3 and leave on edges 3..5.
    bubble();
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      if (e <= 3) drive(1'b1, 1'b0, 1'b0, 1'b0, 32'(e), 5'(e));
      else        bubble();
      step();
      if (e < 3 || e == 6) check($sformatf("s3_edge%0d_valid", e), if3.valid_out, 0);
      else begin
        check($sformatf("s3_edge%0d_valid", e), if3.valid_out, 1);
        check($sformatf("s3_edge%0d_alu", e), if3.alu_result_out, 32'(e - 2));
      end
    end

    // Two-stage stall: full pipe holds for 4 edges, then drains in order.
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd10, 5'd10); step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd11, 5'd11); step();
    check("stall_pre_alu", if2.alu_result_out, 10);
    s_stall = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd99, 5'd3);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("stall_hold%0d_valid", i), if2.valid_out, 1);
      check($sformatf("stall_hold%0d_alu", i), if2.alu_result_out, 10);
    end
    s_stall = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd12, 5'd12); step();
    check("stall_rel_alu11", if2.alu_result_out, 11);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd13, 5'd13); step();
    check("stall_rel_alu12", if2.alu_result_out, 12);
    bubble(); step();
    check("stall_rel_alu13", if2.alu_result_out, 13);
    check("stall_rel_valid13", if2.valid_out, 1);
    step();
    check("stall_drained", if2.valid_out, 0);

    // Flush together with stall empties every stage.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'd77, 5'd7);
    step(); step(); step();
    check("flush_pre_pcsrc", if3.pcsrc_out, 1);
    s_stall = 1'b1; s_flush = 1'b1;
    step();
    check("flush_d1_all", o1, '0);
    check("flush_d2_all", o2, '0);
    check("flush_d3_all", o3, '0);
    s_stall = 1'b0; s_flush = 1'b0;
    bubble(); step();
    check("flush_d3_inner_all", o3, '0);

    // Branch decision, then the same instruction as a bubble.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 5'd0); step();
    check("br_pcsrc", if1.pcsrc_out, 1);
    check("br_branch", if1.Branch_out, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 5'd0); step();
    check("bub_pcsrc", if1.pcsrc_out, 0);
    check("bub_branch", if1.Branch_out, 0);
    check("bub_zero_kept", if1.Zero_out, 1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h1234, 5'd4); step();
    check("bub_regwrite", if1.RegWrite_out, 0);
    check("bub_alu_kept", if1.alu_result_out, 32'h1234);

    // Mid-stream reset discards in-flight work even with stall high.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h55, 5'd5); step(); step();
    reset = 1'b1; s_stall = 1'b1; step();
    reset = 1'b0; s_stall = 1'b0;
    check("midrst_d3_all", o3, '0);
    bubble();
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("midrst_d3_valid%0d", i), if3.valid_out, 0);
    end

`ifdef EXMEM_BUBBLE_CNT_EN
    bubble();
    do_reset();
    check("cnt_reset", if1.bubble_cnt, 0);
    for (int i = 0; i < 5; i++) step();
    check("cnt_five", if1.bubble_cnt, 5);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 5'd1); step();
    check("cnt_six", if1.bubble_cnt, 6);
    s_flush = 1'b1; step(); s_flush = 1'b0;
    check("cnt_flush_keep", if1.bubble_cnt, 6);
    bubble();
    for (int i = 0; i < 65540; i++) step();
    check("cnt_saturate", if1.bubble_cnt, 16'hFFFF);
    step(); step();
    check("cnt_saturate_hold", if1.bubble_cnt, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
